// File: rtl/adma_dm_src_axis.sv
// Source-side AXI-Stream datamover: descriptor FIFO, beat counter, registered output stage.
// Optional macro ADMA_SRC_TKEEP_CHK_EN flags partial TKEEP/TSTRB beats as transaction errors.
module adma_dm_src_axis #(
  parameter int DMA_CHN_NUM      = 4,
  parameter int MST_ID_W         = 5,
  parameter int ATX_LEN_W        = 8,
  parameter int SRC_TDEST_W      = 2,
  parameter int ATX_SRC_DATA_W   = 256,
  parameter int ATX_SRC_BYTE_AMT = ATX_SRC_DATA_W / 8,
  parameter int ATX_NUM_OSTD     = DMA_CHN_NUM,
  localparam int DMA_CHN_NUM_W   = (DMA_CHN_NUM > 1) ? $clog2(DMA_CHN_NUM) : 1
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [DMA_CHN_NUM_W-1:0]    atx_chn_id,
  input  logic [ATX_LEN_W-1:0]        atx_tlen,
  input  logic                        atx_vld,
  output logic                        atx_rdy,
  output logic [ATX_SRC_DATA_W-1:0]   atx_rdata,
  output logic                        atx_rdata_vld,
  input  logic                        atx_rdata_rdy,
  output logic [DMA_CHN_NUM-1:0]      atx_done,
  output logic [DMA_CHN_NUM-1:0]      atx_src_err,
  input  logic [MST_ID_W-1:0]         s_tid_i,
  input  logic [SRC_TDEST_W-1:0]      s_tdest_i,
  input  logic [ATX_SRC_DATA_W-1:0]   s_tdata_i,
  input  logic [ATX_SRC_BYTE_AMT-1:0] s_tkeep_i,
  input  logic [ATX_SRC_BYTE_AMT-1:0] s_tstrb_i,
  input  logic                        s_tlast_i,
  input  logic                        s_tvalid_i,
  output logic                        s_tready_o
);

  localparam int PTR_W = (ATX_NUM_OSTD > 1) ? $clog2(ATX_NUM_OSTD) : 1;
  localparam int CNT_W = $clog2(ATX_NUM_OSTD + 1);
  localparam int ENT_W = DMA_CHN_NUM_W + ATX_LEN_W;

  logic [ENT_W-1:0]          fifo_q [ATX_NUM_OSTD];
  logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]          fill_q, fill_d;
  logic [ATX_LEN_W-1:0]      cnt_q, cnt_d;
  logic                      err_acc_q, err_acc_d;
  logic [ATX_SRC_DATA_W-1:0] rdata_q, rdata_d;
  logic                      rdata_vld_q, rdata_vld_d;
  logic [DMA_CHN_NUM-1:0]    done_q, done_d;
  logic [DMA_CHN_NUM-1:0]    src_err_q, src_err_d;

  logic                      cur_vld_s;
  logic                      full_s;
  logic [DMA_CHN_NUM_W-1:0]  cur_chn_s;
  logic [ATX_LEN_W-1:0]      cur_tlen_s;
  logic                      push_s;
  logic                      pop_s;
  logic                      hs_s;
  logic                      cnt_eq_s;
  logic                      close_s;
  logic                      beat_err_s;
  logic                      close_err_s;
  logic                      unused_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(ATX_NUM_OSTD - 1)) begin
      return '0;
    end else begin
      return ptr + PTR_W'(1);
    end
  endfunction

  assign cur_vld_s  = (fill_q != '0);
  assign full_s     = (fill_q == CNT_W'(ATX_NUM_OSTD));
  assign {cur_chn_s, cur_tlen_s} = fifo_q[rd_ptr_q];

  assign s_tready_o = cur_vld_s & (~rdata_vld_q | atx_rdata_rdy);
  assign hs_s       = s_tvalid_i & s_tready_o;
  assign cnt_eq_s   = (cnt_q == cur_tlen_s);
  assign close_s    = hs_s & (cnt_eq_s | s_tlast_i);
  assign pop_s      = close_s;

  // A closing beat frees the head slot, so a full FIFO may still take a descriptor that cycle.
  assign atx_rdy    = ~full_s | pop_s;
  assign push_s     = atx_vld & atx_rdy;

`ifdef ADMA_SRC_TKEEP_CHK_EN
  assign beat_err_s = hs_s & (~(&s_tkeep_i) | ~(&s_tstrb_i));
  assign unused_s   = ^{s_tid_i, s_tdest_i};
`else
  assign beat_err_s = 1'b0;
  assign unused_s   = ^{s_tid_i, s_tdest_i, s_tkeep_i, s_tstrb_i};
`endif

  // TLAST must coincide exactly with the last expected beat; either mismatch is an error.
  assign close_err_s = (s_tlast_i ^ cnt_eq_s) | beat_err_s;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fill_d      = fill_q;
    cnt_d       = cnt_q;
    err_acc_d   = err_acc_q;
    rdata_d     = rdata_q;
    rdata_vld_d = rdata_vld_q;
    done_d      = '0;
    src_err_d   = '0;

    if (push_s) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   fill_d = fill_q + CNT_W'(1);
      2'b01:   fill_d = fill_q - CNT_W'(1);
      default: fill_d = fill_q;
    endcase

    if (close_s) begin
      cnt_d     = '0;
      err_acc_d = 1'b0;
      done_d[cur_chn_s]    = 1'b1;
      src_err_d[cur_chn_s] = err_acc_q | close_err_s;
    end else if (hs_s) begin
      cnt_d     = cnt_q + ATX_LEN_W'(1);
      err_acc_d = err_acc_q | beat_err_s;
    end else begin
      cnt_d     = cnt_q;
      err_acc_d = err_acc_q;
    end

    if (hs_s) begin
      rdata_d     = s_tdata_i;
      rdata_vld_d = 1'b1;
    end else if (atx_rdata_rdy) begin
      rdata_vld_d = 1'b0;
    end else begin
      rdata_vld_d = rdata_vld_q;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < ATX_NUM_OSTD; i++) begin
        fifo_q[i] <= '0;
      end
    end else if (push_s) begin
      fifo_q[wr_ptr_q] <= {atx_chn_id, atx_tlen};
    end else begin
      fifo_q[wr_ptr_q] <= fifo_q[wr_ptr_q];
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      cnt_q       <= '0;
      err_acc_q   <= 1'b0;
      rdata_q     <= '0;
      rdata_vld_q <= 1'b0;
      done_q      <= '0;
      src_err_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      cnt_q       <= cnt_d;
      err_acc_q   <= err_acc_d;
      rdata_q     <= rdata_d;
      rdata_vld_q <= rdata_vld_d;
      done_q      <= done_d;
      src_err_q   <= src_err_d;
    end
  end

  assign atx_rdata     = rdata_q;
  assign atx_rdata_vld = rdata_vld_q;
  assign atx_done      = done_q;
  assign atx_src_err   = src_err_q;

endmodule

// File: tb/tb_adma_dm_src_axis.sv
// Directed scoreboard bench for adma_dm_src_axis: data and done/err events are queued at
// stimulus time and popped when the DUT emits them.
module tb_adma_dm_src_axis;

  logic         aclk = 1'b0;
  logic         aresetn;
  logic [1:0]   atx_chn_id;
  logic [7:0]   atx_tlen;
  logic         atx_vld;
  logic         atx_rdy;
  logic [255:0] atx_rdata;
  logic         atx_rdata_vld;
  logic         atx_rdata_rdy;
  logic [3:0]   atx_done;
  logic [3:0]   atx_src_err;
  logic [4:0]   s_tid_i;
  logic [1:0]   s_tdest_i;
  logic [255:0] s_tdata_i;
  logic [31:0]  s_tkeep_i;
  logic [31:0]  s_tstrb_i;
  logic         s_tlast_i;
  logic         s_tvalid_i;
  logic         s_tready_o;

  adma_dm_src_axis dut (
    .aclk(aclk), .aresetn(aresetn),
    .atx_chn_id(atx_chn_id), .atx_tlen(atx_tlen), .atx_vld(atx_vld), .atx_rdy(atx_rdy),
    .atx_rdata(atx_rdata), .atx_rdata_vld(atx_rdata_vld), .atx_rdata_rdy(atx_rdata_rdy),
    .atx_done(atx_done), .atx_src_err(atx_src_err),
    .s_tid_i(s_tid_i), .s_tdest_i(s_tdest_i), .s_tdata_i(s_tdata_i), .s_tkeep_i(s_tkeep_i),
    .s_tstrb_i(s_tstrb_i), .s_tlast_i(s_tlast_i), .s_tvalid_i(s_tvalid_i), .s_tready_o(s_tready_o)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [1:0] chn;
    logic [7:0] tlen;
  } desc_t;

  int           total = 0;
  int           bad   = 0;
  desc_t        mdesc_q[$];
  logic [255:0] data_q[$];
  logic [7:0]   ev_q[$];
  int           mcnt = 0;
  logic         merr = 1'b0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] mk_data(input logic [31:0] seed);
    return {8{seed}};
  endfunction

  // Reference behaviour for one accepted beat: closes on count or TLAST, flags mismatches.
  task automatic model_beat(input logic [255:0] d, input logic last, input logic [31:0] keep);
    desc_t hd;
    logic  eq;
    logic  e;
    logic [3:0] oh;
    data_q.push_back(d);
    if (mdesc_q.size() == 0) begin
      check("beat_without_desc", mdesc_q.size(), 1);
      return;
    end
    hd = mdesc_q[0];
    eq = (mcnt == int'(hd.tlen));
`ifdef ADMA_SRC_TKEEP_CHK_EN
    if (keep != 32'hFFFF_FFFF) merr = 1'b1;
`endif
    e  = merr | (last != eq);
    if (eq || last) begin
      oh = 4'b0001 << hd.chn;
      ev_q.push_back({oh, e ? oh : 4'b0000});
      void'(mdesc_q.pop_front());
      mcnt = 0;
      merr = 1'b0;
    end else begin
      mcnt++;
    end
  endtask

  // All tasks start and end at the drive point, 1 time unit after a rising edge.
  task automatic send_beat(input logic [255:0] d, input logic last, input logic [31:0] keep);
    logic hit = 1'b0;
    s_tvalid_i = 1'b1; s_tdata_i = d; s_tlast_i = last; s_tkeep_i = keep; s_tstrb_i = keep;
    for (int i = 0; i < 50; i++) begin
      @(negedge aclk);
      if (s_tready_o) begin
        model_beat(d, last, keep);
        hit = 1'b1;
        @(posedge aclk); #1;
        break;
      end
      @(posedge aclk); #1;
    end
    s_tvalid_i = 1'b0; s_tlast_i = 1'b0;
    if (!hit) check("beat_timeout", hit, 1'b1);
  endtask

  task automatic send_desc(input logic [1:0] chn, input logic [7:0] tlen);
    logic hit = 1'b0;
    atx_vld = 1'b1; atx_chn_id = chn; atx_tlen = tlen;
    for (int i = 0; i < 50; i++) begin
      @(negedge aclk);
      if (atx_rdy) begin
        mdesc_q.push_back('{chn: chn, tlen: tlen});
        hit = 1'b1;
        @(posedge aclk); #1;
        break;
      end
      @(posedge aclk); #1;
    end
    atx_vld = 1'b0;
    if (!hit) check("desc_timeout", hit, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge aclk); #1;
    end
  endtask

  // Output monitor: pops the scoreboard on every consumed beat and every done/err pulse.
  always @(negedge aclk) begin
    logic [255:0] ed;
    logic [7:0]   ev;
    if (aresetn) begin
      if (atx_rdata_vld && atx_rdata_rdy) begin
        if (data_q.size() == 0) begin
          check("extra_beat", atx_rdata_vld, 1'b0);
        end else begin
          ed = data_q.pop_front();
          check("rdata", atx_rdata, ed);
        end
      end
      if (atx_done != 4'b0000 || atx_src_err != 4'b0000) begin
        if (ev_q.size() == 0) begin
          check("extra_done", {atx_done, atx_src_err}, 8'h00);
        end else begin
          ev = ev_q.pop_front();
          check("done", atx_done, ev[7:4]);
          check("src_err", atx_src_err, ev[3:0]);
          check("done_align", atx_rdata_vld, 1'b1);
        end
      end
    end
  end

  initial begin
    aresetn = 1'b0; atx_chn_id = 2'd0; atx_tlen = 8'd0; atx_vld = 1'b0; atx_rdata_rdy = 1'b1;
    s_tid_i = 5'd0; s_tdest_i = 2'd0; s_tdata_i = '0; s_tkeep_i = 32'hFFFF_FFFF;
    s_tstrb_i = 32'hFFFF_FFFF; s_tlast_i = 1'b0; s_tvalid_i = 1'b0;

    // Reset state
    repeat (2) @(negedge aclk);
    check("rst_rdata_vld", atx_rdata_vld, 1'b0);
    check("rst_rdata", atx_rdata, 256'h0);
    check("rst_done", atx_done, 4'b0000);
    check("rst_err", atx_src_err, 4'b0000);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(negedge aclk);
    check("rst_atx_rdy", atx_rdy, 1'b1);
    check("rst_tready", s_tready_o, 1'b0);
    @(posedge aclk); #1;

    // Basic 4-beat packet on channel 2, back to back
    send_desc(2'd2, 8'd3);
    for (int i = 0; i < 4; i++) send_beat(mk_data(32'hD000_0000 + i), i == 3, 32'hFFFF_FFFF);
    idle(3);

    // Fill the descriptor FIFO without stream traffic
    for (int i = 0; i < 4; i++) send_desc(2'(i), 8'd0);
    @(negedge aclk);
    check("full_atx_rdy", atx_rdy, 1'b0);
    @(posedge aclk); #1;
    // Push and close in the same cycle while full
    atx_vld = 1'b1; atx_chn_id = 2'd1; atx_tlen = 8'd0;
    s_tvalid_i = 1'b1; s_tdata_i = mk_data(32'hF0F0_0000); s_tlast_i = 1'b1;
    s_tkeep_i = 32'hFFFF_FFFF; s_tstrb_i = 32'hFFFF_FFFF;
    @(negedge aclk);
    check("full_pop_tready", s_tready_o, 1'b1);
    check("full_pop_atx_rdy", atx_rdy, 1'b1);
    if (s_tready_o) model_beat(s_tdata_i, 1'b1, 32'hFFFF_FFFF);
    if (atx_rdy) mdesc_q.push_back('{chn: 2'd1, tlen: 8'd0});
    @(posedge aclk); #1;
    atx_vld = 1'b0; s_tvalid_i = 1'b0; s_tlast_i = 1'b0;
    @(negedge aclk);
    check("still_full_atx_rdy", atx_rdy, 1'b0);
    @(posedge aclk); #1;
    for (int i = 0; i < 4; i++) send_beat(mk_data(32'hF1F1_0000 + i), 1'b1, 32'hFFFF_FFFF);
    idle(3);

    // Early TLAST on channel 1, then a clean 2-beat packet on channel 2
    send_desc(2'd1, 8'd7);
    send_desc(2'd2, 8'd1);
    for (int i = 0; i < 4; i++) send_beat(mk_data(32'hE000_0000 + i), i == 3, 32'hFFFF_FFFF);
    for (int i = 0; i < 2; i++) send_beat(mk_data(32'hE100_0000 + i), i == 1, 32'hFFFF_FFFF);
    idle(3);

    // Missing TLAST on channel 0; third beat belongs to channel 3 (tlen=0)
    send_desc(2'd0, 8'd1);
    send_desc(2'd3, 8'd0);
    send_beat(mk_data(32'hA000_0000), 1'b0, 32'hFFFF_FFFF);
    send_beat(mk_data(32'hA000_0001), 1'b0, 32'hFFFF_FFFF);
    send_beat(mk_data(32'hA000_0002), 1'b1, 32'hFFFF_FFFF);
    idle(3);

    // Downstream stall for 5 cycles mid-packet
    send_desc(2'd2, 8'd5);
    send_beat(mk_data(32'hB000_0000), 1'b0, 32'hFFFF_FFFF);
    atx_rdata_rdy = 1'b0;
    s_tvalid_i = 1'b1; s_tdata_i = mk_data(32'hB000_0001);
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check("stall_tready", s_tready_o, 1'b0);
      @(posedge aclk); #1;
    end
    atx_rdata_rdy = 1'b1;
    for (int i = 1; i < 6; i++) send_beat(mk_data(32'hB000_0000 + i), i == 5, 32'hFFFF_FFFF);
    idle(3);

    // Reset mid-packet discards descriptors and in-flight data
    send_desc(2'd1, 8'd3);
    send_desc(2'd0, 8'd2);
    send_beat(mk_data(32'hC000_0000), 1'b0, 32'hFFFF_FFFF);
    send_beat(mk_data(32'hC000_0001), 1'b0, 32'hFFFF_FFFF);
    aresetn = 1'b0;
    data_q.delete(); ev_q.delete(); mdesc_q.delete(); mcnt = 0; merr = 1'b0;
    @(negedge aclk);
    check("mid_rst_vld", atx_rdata_vld, 1'b0);
    check("mid_rst_rdata", atx_rdata, 256'h0);
    check("mid_rst_done", atx_done, 4'b0000);
    check("mid_rst_err", atx_src_err, 4'b0000);
    check("mid_rst_atx_rdy", atx_rdy, 1'b1);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(negedge aclk);
    check("post_rst_tready", s_tready_o, 1'b0);
    @(posedge aclk); #1;
    send_desc(2'd3, 8'd0);
    send_beat(mk_data(32'hC100_0000), 1'b1, 32'hFFFF_FFFF);
    idle(3);

    // Partial TKEEP on first beat; errors only when the check is built in
    send_desc(2'd0, 8'd1);
    send_beat(mk_data(32'h7000_0000), 1'b0, 32'hFFFF_FFFE);
    send_beat(mk_data(32'h7000_0001), 1'b1, 32'hFFFF_FFFF);
    idle(5);

    check("data_q_empty", data_q.size(), 0);
    check("ev_q_empty", ev_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
